// File: rtl/riscv_pkg.sv
// Shared core definitions: register-file geometry and the writeback entry payload.
package riscv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries with a combinational head.
// Push is ignored when full and pop is ignored when empty.
module wb_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  wb_entry_t                push_entry,
    input  logic                     pop,
    output wb_entry_t                head_c,
    output logic                     full_c,
    output logic                     empty_c,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_entry_t          mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full_c  = (count == CNT_W'(DEPTH));
    assign empty_c = (count == '0);
    assign head_c  = mem[rd_ptr];
    assign do_push = push && !full_c;
    assign do_pop  = pop && !empty_c;

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: ALU results win, buffered load results
// drain on ALU-idle cycles; also tracks registers with outstanding loads.
module writeback_arbiter #(
    parameter int unsigned XLEN       = riscv_pkg::XLEN,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                alu_valid,
    input  logic [riscv_pkg::REG_ADDR_W-1:0]    alu_rd,
    input  logic [XLEN-1:0]                     alu_data,
    input  logic                                ld_valid,
    output logic                                ld_ready,
    input  logic [riscv_pkg::REG_ADDR_W-1:0]    ld_rd,
    input  logic [XLEN-1:0]                     ld_data,
    input  logic                                issue_load,
    input  logic [riscv_pkg::REG_ADDR_W-1:0]    issue_rd,
    output logic [riscv_pkg::NUM_REGS-1:0]      busy,
    output logic [$clog2(FIFO_DEPTH):0]         pending_cnt,
    output logic [riscv_pkg::REG_ADDR_W-1:0]    rd,
    output logic [XLEN-1:0]                     rd_data,
    output logic                                reg_write
);

    import riscv_pkg::*;

    wb_entry_t              push_entry;
    wb_entry_t              head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   alu_sel;
    logic [NUM_REGS-1:0]    busy_nxt;

    wb_fifo #(
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .head_c     (head),
        .full_c     (fifo_full),
        .empty_c    (fifo_empty),
        .count      (pending_cnt)
    );

    assign ld_ready = !fifo_full;

    // Source selection; x0 traffic never reaches the port or the FIFO.
    always_comb begin
        alu_sel    = alu_valid && (alu_rd != '0);
        fifo_push  = ld_valid && ld_ready && (ld_rd != '0);
        fifo_pop   = !alu_sel && !fifo_empty;
        push_entry = '{rd: ld_rd, data: ld_data};
    end

    // Scoreboard update: a new issue overrides a same-cycle writeback clear.
    always_comb begin
        busy_nxt = busy;
        if (fifo_pop) begin
            busy_nxt[head.rd] = 1'b0;
        end
        if (issue_load && (issue_rd != '0)) begin
            busy_nxt[issue_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd        <= '0;
            rd_data   <= '0;
            reg_write <= 1'b0;
            busy      <= '0;
        end else begin
            busy <= busy_nxt;
            if (alu_sel) begin
                rd        <= alu_rd;
                rd_data   <= alu_data;
                reg_write <= 1'b1;
            end else if (fifo_pop) begin
                rd        <= head.rd;
                rd_data   <= head.data;
                reg_write <= 1'b1;
            end else begin
                reg_write <= 1'b0;
            end
        end
    end

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Drives the register file's single write port (rd, rd_data, reg_write) from two producers: the single-cycle ALU path and the variable-latency load unit. ALU results always win the port. Load results are buffered in a small FIFO and drained on ALU-idle cycles. The block also keeps a pending-load scoreboard that the hazard logic uses to stall readers of registers whose load has not yet been written back.

## Interface
- XLEN, 32, data width
- FIFO_DEPTH, 4, load-result buffer entries (power of two, ≥2)

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU result valid this cycle (no backpressure)
- alu_rd  in  5  ALU destination register
- alu_data  in  XLEN  ALU result
- ld_valid  in  1  load result offered
- ld_ready  out  1  load result can be accepted (FIFO not full)
- ld_rd  in  5  load destination register
- ld_data  in  XLEN  load result
- issue_load  in  1  a load with destination issue_rd is issued this cycle
- issue_rd  in  5  destination of the issued load
- busy  out  32  bit i = load to xi outstanding (issued, not yet written)
- pending_cnt  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- rd  out  5  register file write address
- rd_data  out  XLEN  register file write data
- reg_write  out  1  register file write enable

## Operation
- Each cycle, select one write source:
  - ALU if alu_valid and alu_rd≠0;
  - otherwise the FIFO head if the FIFO is non-empty (pop);
  - otherwise none.
- Selected write is registered into rd/rd_data/reg_write. With no selection, reg_write=0 and rd/rd_data hold their previous values.
- reg_write is never asserted with rd=0.
  - ALU writes to x0 are dropped and do not consume the slot, so the FIFO may drain that cycle.
  - Loads to x0 are accepted (handshake completes) but not enqueued.
- Load handshake: a transfer occurs on a rising edge where ld_valid && ld_ready. ld_ready = (pending_cnt < FIFO_DEPTH), combinational from registered state only.
- Simultaneous push and pop when full is not possible: ld_ready=0 when full. Push and pop in the same cycle when non-empty keeps pending_cnt unchanged.
- Scoreboard:
  - issue_load with issue_rd≠0 sets busy[issue_rd].
  - A load write leaving the FIFO to the register file clears busy[rd] on the edge on which reg_write is registered high.
  - Same-cycle set and clear of the same bit: set wins.
  - busy[0] is constantly 0.
- Protocol rules (hazard unit's obligation; assertions in the bench):
  - No issue_load to a register already busy.
  - No alu_valid to a register that is busy.
- Reset (any time, including mid-drain): FIFO emptied, busy cleared, in-flight load data discarded, reg_write deasserted asynchronously.

## Timing
- Reset values: rd=0, rd_data=0, reg_write=0, busy=0, pending_cnt=0, ld_ready=1.
- ALU latency: alu_valid sampled at edge N → reg_write=1 during cycle N→N+1 (one cycle), written into the register file at edge N+1.
- Load latency: accepted at edge N, FIFO empty, no ALU at cycle N+1 → popped at edge N+1, reg_write high after edge N+1, written into the register file at edge N+2. busy clears at edge N+1.
- There is no FIFO bypass; minimum load latency is 2 edges from acceptance to register file write.
- Sustained ALU traffic starves the FIFO. ld_ready drops once FIFO_DEPTH loads are pending and stays low until an ALU-idle cycle pops one.
- Throughput: one register file write per cycle maximum.

## Structure
- Shared package riscv_pkg holds XLEN, REG_ADDR_W=5, NUM_REGS=32, and the wb_entry_t typedef {rd, data}.
- One sub-module, wb_fifo: synchronous FIFO of wb_entry_t with push/pop, full/empty, count, async active-high reset, and combinational head output.
- The arbiter mux, output registers and scoreboard sit in writeback_arbiter.

## Test plan
- Reset release, then alu_valid, alu_rd=5, alu_data=0x1234 → next cycle reg_write=1, rd=5, rd_data=0x1234; x0 untouched.
- issue_load rd=7, then load ld_rd=7, ld_data=0xCAFEBABE with the ALU idle → busy[7]=1 until reg_write=1, rd=7 two edges after acceptance, then busy[7]=0.
- Continuous ALU writes while 5 loads are offered with FIFO_DEPTH=4 → 4 accepted, ld_ready=0, pending_cnt=4. On the first ALU-idle cycle, load 1 writes and ld_ready returns to 1. Results come out in FIFO order.
- alu_rd=0 with alu_valid plus a pending load → no x0 write; the load drains that same cycle. A load with ld_rd=0 is accepted and pending_cnt does not increase.
- Same cycle: load to x9 pops (clears busy[9]) while issue_load rd=9 → busy[9]=1 afterwards.
- Assert rst mid-drain with pending_cnt=3 → reg_write=0 immediately, pending_cnt=0, busy=0, ld_ready=1; no further writes occur after release.
